// File: rtl/dispatch_queue_if.sv
// Decoded-entry payload type and the decoder/dispatch handshake bundle.
//
// Package dispatch_queue_pkg:
//   id_dispatch_t  - one decoded instruction; an all-zero entry (pc == 0) marks an empty slot.
//
// Interface dispatch_queue_if #(DEPTH):
//   flush       ctrl  -> queue  pipeline flush
//   push_valid  dec   -> queue  per-slot valid for push_i, bit 0 is older
//   push_i      dec   -> queue  two decoded entries
//   push_ready  queue -> dec    room for two entries this cycle
//   invalid_en  disp  -> queue  issue mask, selects how many head entries retire
//   dispatch_o  queue -> disp   two oldest entries, slot 0 oldest, zero when empty
//   head_valid  queue -> disp   per-slot occupancy of dispatch_o
//   count       queue -> disp   current occupancy
//   modport master: the decoder/ctrl/dispatch side; modport slave: the queue.

package dispatch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  fu_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
  } id_dispatch_t;

endpackage

interface dispatch_queue_if #(
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                                      flush;
  logic [1:0]                                push_valid;
  dispatch_queue_pkg::id_dispatch_t [1:0]    push_i;
  logic                                      push_ready;
  logic [1:0]                                invalid_en;
  dispatch_queue_pkg::id_dispatch_t [1:0]    dispatch_o;
  logic [1:0]                                head_valid;
  logic [CNT_W-1:0]                          count;

  modport master (
    output flush,
    output push_valid,
    output push_i,
    output invalid_en,
    input  push_ready,
    input  dispatch_o,
    input  head_valid,
    input  count
  );

  modport slave (
    input  flush,
    input  push_valid,
    input  push_i,
    input  invalid_en,
    output push_ready,
    output dispatch_o,
    output head_valid,
    output count
  );

endinterface

// File: rtl/dispatch_queue.sv
// Dual-push / dual-pop in-order instruction queue between decode and dispatch.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   dq    slave modport of dispatch_queue_if (push side, head outputs, retire mask, flush)
//
// Entries are packed compactly at the tail in program order; the two oldest
// entries are presented combinationally from the registered array, masked to
// zero when the slot is empty.

module dispatch_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  dispatch_queue_if.slave   dq
);

  import dispatch_queue_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  id_dispatch_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push_ready;
  logic               w_push_en;
  logic [1:0]         w_npush;
  logic [1:0]         w_npop_req;
  logic [1:0]         w_npop;
  logic               w_wr0_en;
  logic               w_wr1_en;
  id_dispatch_t       w_wr0_data;
  id_dispatch_t       w_wr1_data;
  logic [PTR_W-1:0]   w_tail1;
  logic [PTR_W-1:0]   w_head1;
  logic [1:0]         w_head_valid;

  // Space check uses the registered count only; a same-cycle pop never frees room.
  assign w_push_ready = (r_count <= CNT_W'(DEPTH - 2));
  assign w_push_en    = w_push_ready && !dq.flush && !rst;

  assign w_tail1 = r_tail + PTR_W'(1);
  assign w_head1 = r_head + PTR_W'(1);

  // Push decode: a lone slot-1 entry is written at tail so the queue stays compact.
  always_comb begin
    w_wr0_en   = 1'b0;
    w_wr1_en   = 1'b0;
    w_wr0_data = dq.push_i[0];
    w_wr1_data = dq.push_i[1];
    w_npush    = 2'd0;
    if (w_push_en) begin
      case (dq.push_valid)
        2'b11: begin
          w_wr0_en = 1'b1;
          w_wr1_en = 1'b1;
          w_npush  = 2'd2;
        end
        2'b01: begin
          w_wr0_en = 1'b1;
          w_npush  = 2'd1;
        end
        2'b10: begin
          w_wr0_en   = 1'b1;
          w_wr0_data = dq.push_i[1];
          w_npush    = 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Retire count from the issue mask, clipped to the current occupancy.
  always_comb begin
    w_npop_req = 2'd0;
    case (dq.invalid_en)
      2'b11:        w_npop_req = 2'd2;
      2'b01, 2'b10: w_npop_req = 2'd1;
      default:      w_npop_req = 2'd0;
    endcase
    w_npop = w_npop_req;
    if (r_count < CNT_W'(w_npop_req)) begin
      w_npop = r_count[1:0];
    end
  end

  // Pointer and occupancy state; flush and reset discard that cycle's push and pop.
  always_ff @(posedge clk) begin
    if (rst || dq.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_npop);
      r_tail  <= r_tail + PTR_W'(w_npush);
      r_count <= r_count + CNT_W'(w_npush) - CNT_W'(w_npop);
    end
  end

  // Entry storage; contents need no reset since empty slots are masked on output.
  always_ff @(posedge clk) begin
    if (w_wr0_en) begin
      r_mem[r_tail] <= w_wr0_data;
    end
    if (w_wr1_en) begin
      r_mem[w_tail1] <= w_wr1_data;
    end
  end

  // Head presentation.
  assign w_head_valid     = {(r_count >= CNT_W'(2)), (r_count != '0)};
  assign dq.head_valid    = w_head_valid;
  assign dq.dispatch_o[0] = w_head_valid[0] ? r_mem[r_head]  : '0;
  assign dq.dispatch_o[1] = w_head_valid[1] ? r_mem[w_head1] : '0;
  assign dq.push_ready    = w_push_ready;
  assign dq.count         = r_count;

  // Structural invariants of the ring.
  a_count_max : assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(DEPTH));
  a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
    r_tail == PTR_W'(r_head + r_count[PTR_W-1:0]));

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed table, hand sequences for
// full/flush/reset/wrap corners, and randomized traffic against a queue model.

module tb_dispatch_queue;

  import dispatch_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_queue_if #(.DEPTH(DEPTH)) dq ();

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .dq  (dq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  id_dispatch_t mq[$];

  typedef struct packed {
    logic        r;
    logic        f;
    logic [1:0]  pv;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  inv;
    logic [4:0]  ecnt;
    logic [1:0]  ehv;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic        erdy;
  } vec_t;

  vec_t tbl [11];

  function automatic id_dispatch_t mk(input logic [31:0] pc);
    id_dispatch_t e;
    e.pc      = pc;
    e.instr   = pc ^ 32'hA5A5_0F0F;
    e.fu_type = pc[5:2];
    e.rd      = pc[6:2];
    e.rs1     = pc[11:7];
    e.rs2     = pc[16:12];
    e.rd_we   = pc[2];
    return e;
  endfunction

  function automatic id_dispatch_t exp_ent(input logic [31:0] pc);
    return (pc == 32'd0) ? id_dispatch_t'(0) : mk(pc);
  endfunction

  function automatic vec_t mkv(input logic r, input logic f, input logic [1:0] pv,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] inv, input logic [4:0] ecnt,
                               input logic [1:0] ehv, input logic [31:0] epc0,
                               input logic [31:0] epc1, input logic erdy);
    vec_t v;
    v.r = r; v.f = f; v.pv = pv; v.pc0 = pc0; v.pc1 = pc1; v.inv = inv;
    v.ecnt = ecnt; v.ehv = ehv; v.epc0 = epc0; v.epc1 = epc1; v.erdy = erdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare DUT outputs against the queue model.
  task automatic check_model();
    int sz;
    id_dispatch_t d0;
    id_dispatch_t d1;
    sz = mq.size();
    d0 = (sz >= 1) ? mq[0] : id_dispatch_t'(0);
    d1 = (sz >= 2) ? mq[1] : id_dispatch_t'(0);
    check("model_count", 128'(dq.count), 128'(sz));
    check("model_head_valid", 128'(dq.head_valid), 128'({(sz >= 2), (sz >= 1)}));
    check("model_push_ready", 128'(dq.push_ready), 128'((int'(DEPTH) - sz) >= 2));
    check("model_dispatch0", 128'(dq.dispatch_o[0]), 128'(d0));
    check("model_dispatch1", 128'(dq.dispatch_o[1]), 128'(d1));
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic cycle(input logic r, input logic f, input logic [1:0] pv,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic [1:0] inv);
    id_dispatch_t e0;
    id_dispatch_t e1;
    int sz;
    int req;
    int np;
    bit rdy;
    e0 = mk(pc0);
    e1 = mk(pc1);
    rst           = r;
    dq.flush      = f;
    dq.push_valid = pv;
    dq.push_i[0]  = e0;
    dq.push_i[1]  = e1;
    dq.invalid_en = inv;
    @(posedge clk);
    sz  = mq.size();
    rdy = (int'(DEPTH) - sz) >= 2;
    req = (inv == 2'b11) ? 2 : ((inv == 2'b00) ? 0 : 1);
    np  = (req < sz) ? req : sz;
    if (r || f) begin
      mq.delete();
    end else begin
      repeat (np) void'(mq.pop_front());
      if (rdy) begin
        if (pv[0]) mq.push_back(e0);
        if (pv[1]) mq.push_back(e1);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic check_now(input string tag, input int ecnt, input logic [1:0] ehv,
                           input logic [31:0] epc0, input logic [31:0] epc1, input logic erdy);
    check({tag, "_count"}, 128'(dq.count), 128'(ecnt));
    check({tag, "_head_valid"}, 128'(dq.head_valid), 128'(ehv));
    check({tag, "_dispatch0"}, 128'(dq.dispatch_o[0]), 128'(exp_ent(epc0)));
    check({tag, "_dispatch1"}, 128'(dq.dispatch_o[1]), 128'(exp_ent(epc1)));
    check({tag, "_push_ready"}, 128'(dq.push_ready), 128'(erdy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pc_seq;
    logic [31:0] pushed[$];
    logic [31:0] popped[$];
    int n_pushed;
    logic [1:0] pv;
    logic [1:0] inv;
    int avail;
    int req;

    rst = 1'b1;
    dq.flush = 1'b0;
    dq.push_valid = 2'b00;
    dq.push_i = '0;
    dq.invalid_en = 2'b00;

    // Directed table: expected values are the state visible after each edge.
    tbl[0]  = mkv(1, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1);
    tbl[1]  = mkv(0, 0, 2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00,
                  2, 2'b11, 32'h1c00_0000, 32'h1c00_0004, 1);
    tbl[2]  = mkv(0, 1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1);
    tbl[3]  = mkv(0, 0, 2'b01, 32'h100, 32'hdead, 2'b00, 1, 2'b01, 32'h100, 0, 1);
    tbl[4]  = mkv(0, 0, 2'b10, 32'hbad, 32'h104, 2'b00, 2, 2'b11, 32'h100, 32'h104, 1);
    tbl[5]  = mkv(0, 0, 2'b11, 32'h108, 32'h10c, 2'b00, 4, 2'b11, 32'h100, 32'h104, 1);
    tbl[6]  = mkv(0, 0, 2'b00, 0, 0, 2'b01, 3, 2'b11, 32'h104, 32'h108, 1);
    tbl[7]  = mkv(0, 0, 2'b00, 0, 0, 2'b11, 1, 2'b01, 32'h10c, 0, 1);
    tbl[8]  = mkv(0, 0, 2'b01, 32'h200, 32'h0, 2'b11, 1, 2'b01, 32'h200, 0, 1);
    tbl[9]  = mkv(0, 0, 2'b00, 0, 0, 2'b11, 0, 2'b00, 0, 0, 1);
    tbl[10] = mkv(0, 0, 2'b00, 0, 0, 2'b11, 0, 2'b00, 0, 0, 1);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].f, tbl[i].pv, tbl[i].pc0, tbl[i].pc1, tbl[i].inv);
      check_now($sformatf("tbl%0d", i), int'(tbl[i].ecnt), tbl[i].ehv,
                tbl[i].epc0, tbl[i].epc1, tbl[i].erdy);
    end

    // Fill to DEPTH-1, then a push with a simultaneous double pop is dropped.
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 2'b11, 32'h3000 + 32'(8 * k), 32'h3004 + 32'(8 * k), 2'b00);
    end
    cycle(0, 0, 2'b01, 32'h3038, 32'h0, 2'b00);
    check_now("full", 15, 2'b11, 32'h3000, 32'h3004, 0);
    cycle(0, 0, 2'b11, 32'h4000, 32'h4004, 2'b11);
    check_now("full_pop", 13, 2'b11, 32'h3008, 32'h300c, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 2'b00, 0, 0, 2'b11);
    check_now("full_drain", 1, 2'b01, 32'h3038, 0, 1);
    cycle(0, 0, 2'b00, 0, 0, 2'b01);
    check_now("full_empty", 0, 2'b00, 0, 0, 1);

    // Flush with count 6 while pushing two and popping two.
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 2'b11, 32'h5000 + 32'(8 * k), 32'h5004 + 32'(8 * k), 2'b00);
    end
    check_now("pre_flush", 6, 2'b11, 32'h5000, 32'h5004, 1);
    cycle(0, 1, 2'b11, 32'h6000, 32'h6004, 2'b11);
    check_now("flush", 0, 2'b00, 0, 0, 1);
    cycle(0, 0, 2'b01, 32'h7000, 32'h0, 2'b00);
    check_now("post_flush", 1, 2'b01, 32'h7000, 0, 1);

    // Reset mid-stream.
    cycle(0, 0, 2'b11, 32'h7100, 32'h7104, 2'b00);
    cycle(1, 0, 2'b11, 32'h7200, 32'h7204, 2'b11);
    check_now("mid_rst", 0, 2'b00, 0, 0, 1);
    cycle(0, 0, 2'b10, 32'h0, 32'h7300, 2'b00);
    check_now("post_rst", 1, 2'b01, 32'h7300, 0, 1);
    cycle(0, 0, 2'b00, 0, 0, 2'b01);

    // Wrap scoreboard: 40 entries in mixed widths, order observed at dispatch.
    n_pushed = 0;
    pc_seq = 32'h8000;
    for (int c = 0; c < 200 && (n_pushed < 40 || dq.count != 0); c++) begin
      pv  = 2'b00;
      if (n_pushed < 40) begin
        case (c % 3)
          0: pv = 2'b01;
          1: pv = (n_pushed <= 38) ? 2'b11 : 2'b01;
          default: pv = 2'b10;
        endcase
      end
      inv = (n_pushed >= 40 || c % 4 == 3) ? 2'b11 : ((c % 4 == 1) ? 2'b10 : 2'b00);
      avail = (dq.head_valid == 2'b11) ? 2 : ((dq.head_valid == 2'b01) ? 1 : 0);
      req = (inv == 2'b11) ? 2 : ((inv == 2'b00) ? 0 : 1);
      if (req < avail) avail = req;
      for (int j = 0; j < avail; j++) popped.push_back(dq.dispatch_o[j].pc);
      if (dq.push_ready) begin
        if (pv[0]) begin pushed.push_back(pc_seq); n_pushed++; end
        if (pv[1]) begin pushed.push_back(pc_seq + 4); n_pushed++; end
      end
      cycle(0, 0, pv, pc_seq, pc_seq + 4, inv);
      pc_seq += 8;
    end
    check("wrap_len", 128'(popped.size()), 128'(pushed.size()));
    for (int j = 0; j < pushed.size() && j < popped.size(); j++) begin
      check($sformatf("wrap_order%0d", j), 128'(popped[j]), 128'(pushed[j]));
    end

    // Randomized traffic in push-heavy, pop-heavy and mixed phases.
    pc_seq = 32'h1000_0000;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 300; c++) begin
        logic r;
        logic f;
        pv  = 2'($urandom_range(0, 3));
        inv = 2'($urandom_range(0, 3));
        r = 1'b0;
        f = 1'b0;
        if (ph == 0 && $urandom_range(0, 3) != 0) inv = 2'b00;
        if (ph == 1 && $urandom_range(0, 3) != 0) pv = 2'b00;
        if (ph == 2) begin
          f = ($urandom_range(0, 39) == 0);
          r = ($urandom_range(0, 79) == 0);
        end
        cycle(r, f, pv, pc_seq, pc_seq + 4, inv);
        pc_seq += 8;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
